// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 receiver address map, Code-B glyph table and reset values
package max7219_pkg;

  typedef enum logic [3:0] {
    ADDR_NOOP       = 4'h0,
    ADDR_DIGIT0     = 4'h1,
    ADDR_DIGIT1     = 4'h2,
    ADDR_DIGIT2     = 4'h3,
    ADDR_DIGIT3     = 4'h4,
    ADDR_DIGIT4     = 4'h5,
    ADDR_DIGIT5     = 4'h6,
    ADDR_DIGIT6     = 4'h7,
    ADDR_DIGIT7     = 4'h8,
    ADDR_DECODE     = 4'h9,
    ADDR_INTENSITY  = 4'hA,
    ADDR_SCAN_LIMIT = 4'hB,
    ADDR_SHUTDOWN   = 4'hC,
    ADDR_TEST       = 4'hF
  } addr_e;

  // Segments A..G in bits 6..0, indexed by the Code-B nibble (0-9, '-', E, H, L, P, blank).
  localparam logic [15:0][6:0] CODE_B_GLYPH = {
    7'h00, 7'h67, 7'h0E, 7'h37, 7'h4F, 7'h01, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  localparam logic [7:0] RST_DIGIT      = 8'h00;
  localparam logic [7:0] RST_DECODE     = 8'h00;
  localparam logic [3:0] RST_INTENSITY  = 4'h0;
  localparam logic [2:0] RST_SCAN_LIMIT = 3'h0;
  localparam logic       RST_SHUTDOWN   = 1'b1;
  localparam logic       RST_TEST       = 1'b0;

endpackage

// File: rtl/max7219_rx_if.sv
// rtl/max7219_rx_if.sv - three-wire MAX7219 display link plus chain output
interface max7219_rx_if;
  logic spi_din;
  logic spi_clk;
  logic spi_load;
  logic spi_dout;

  modport master (output spi_din, spi_clk, spi_load, input spi_dout);
  modport slave  (input spi_din, spi_clk, spi_load, output spi_dout);
endinterface

// File: rtl/max7219_code_b.sv
// rtl/max7219_code_b.sv - Code-B digit to segment decoder, DP passed through from bit 7
module max7219_code_b
  import max7219_pkg::*;
(
  input  logic [7:0] digit,
  output logic [7:0] seg
);
  logic unused_hi;
  assign unused_hi = ^digit[6:4];

  assign seg = {digit[7], CODE_B_GLYPH[digit[3:0]]};
endmodule

// File: rtl/max7219_rx.sv
// rtl/max7219_rx.sv - oversampling MAX7219 daisy-chain receiver with decoded register file
// Define MAX7219_RX_DECODE_EN to Code-B decode seg_vector for digits selected by decode mode.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int DEVICES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  max7219_rx_if.slave             spi,
  output logic [64*DEVICES-1:0]   digit_vector,
  output logic [64*DEVICES-1:0]   seg_vector,
  output logic [8*DEVICES-1:0]    decode_vec,
  output logic [4*DEVICES-1:0]    intensity_vec,
  output logic [3*DEVICES-1:0]    scan_limit_vec,
  output logic [DEVICES-1:0]      shutdown_vec,
  output logic [DEVICES-1:0]      test_vec,
  output logic                    update,
  output logic                    frame_err
);
  localparam int N  = 16 * DEVICES;
  localparam int CW = $clog2(N + 2);

  logic [1:0]    din_s;
  logic [2:0]    clk_s;
  logic [2:0]    load_s;
  logic          clk_rise;
  logic          load_rise;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          latch_pend;
  logic          err_pend;

  logic [DEVICES-1:0][7:0][7:0] digit_q;
  logic [DEVICES-1:0][7:0]      decode_q;
  logic [DEVICES-1:0][3:0]      intensity_q;
  logic [DEVICES-1:0][2:0]      scan_q;
  logic [DEVICES-1:0]           shutdown_q;
  logic [DEVICES-1:0]           test_q;

  // Bits [1:0] synchronize, bit [2] is the previous sample for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_s  <= '0;
      clk_s  <= '0;
      load_s <= '0;
    end else begin
      din_s  <= {din_s[0], spi.spi_din};
      clk_s  <= {clk_s[1:0], spi.spi_clk};
      load_s <= {load_s[1:0], spi.spi_load};
    end
  end

  assign clk_rise  = clk_s[1] & ~clk_s[2];
  assign load_rise = load_s[1] & ~load_s[2];
  assign cnt_next  = (clk_rise && cnt != CW'(N + 1)) ? cnt + CW'(1) : cnt;

  // A bit arriving with the load rise is counted into the frame being latched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr         <= '0;
      cnt        <= '0;
      latch_pend <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      if (clk_rise)
        sr <= {sr[N-2:0], din_s[1]};
      latch_pend <= load_rise;
      if (load_rise) begin
        err_pend <= (cnt_next != CW'(N));
        cnt      <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q     <= {(8*DEVICES){RST_DIGIT}};
      decode_q    <= {DEVICES{RST_DECODE}};
      intensity_q <= {DEVICES{RST_INTENSITY}};
      scan_q      <= {DEVICES{RST_SCAN_LIMIT}};
      shutdown_q  <= {DEVICES{RST_SHUTDOWN}};
      test_q      <= {DEVICES{RST_TEST}};
      update      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      update <= latch_pend;
      if (latch_pend) begin
        frame_err <= err_pend;
        for (int d = 0; d < DEVICES; d++) begin
          case (sr[16*d+8 +: 4])
            ADDR_NOOP: ;
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
              digit_q[d][sr[16*d+8 +: 3] - 3'd1] <= sr[16*d +: 8];
            ADDR_DECODE:     decode_q[d]    <= sr[16*d +: 8];
            ADDR_INTENSITY:  intensity_q[d] <= sr[16*d +: 4];
            ADDR_SCAN_LIMIT: scan_q[d]      <= sr[16*d +: 3];
            ADDR_SHUTDOWN:   shutdown_q[d]  <= ~sr[16*d];
            ADDR_TEST:       test_q[d]      <= sr[16*d];
            default: ;
          endcase
        end
      end
    end
  end

  assign spi.spi_dout    = sr[N-1];
  assign digit_vector    = digit_q;
  assign decode_vec      = decode_q;
  assign intensity_vec   = intensity_q;
  assign scan_limit_vec  = scan_q;
  assign shutdown_vec    = shutdown_q;
  assign test_vec        = test_q;

`ifdef MAX7219_RX_DECODE_EN
  logic [DEVICES-1:0][7:0][7:0] seg_w;
  for (genvar d = 0; d < DEVICES; d++) begin : g_dev
    for (genvar n = 0; n < 8; n++) begin : g_dig
      logic [7:0] glyph;
      max7219_code_b u_code_b (
        .digit (digit_q[d][n]),
        .seg   (glyph)
      );
      assign seg_w[d][n] = decode_q[d][n] ? glyph : digit_q[d][n];
    end
  end
  assign seg_vector = seg_w;
`else
  assign seg_vector = digit_q;
`endif

endmodule

// File: tb/tb_max7219_rx.sv
// tb/tb_max7219_rx.sv - self-checking bench for max7219_rx with DEVICES = 2
module tb_max7219_rx;
  localparam int DEVICES = 2;

  typedef struct {
    int           id;
    logic [127:0] digit;
    logic [127:0] seg;
    logic [15:0]  decode;
    logic [7:0]   inten;
    logic [5:0]   scan;
    logic [1:0]   shut;
    logic [1:0]   test;
    logic         err;
    logic         dout;
  } exp_t;

  typedef struct {
    int          nbits;
    logic [95:0] bits;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  max7219_rx_if spi_if ();

  logic [127:0] digit_vector;
  logic [127:0] seg_vector;
  logic [15:0]  decode_vec;
  logic [7:0]   intensity_vec;
  logic [5:0]   scan_limit_vec;
  logic [1:0]   shutdown_vec;
  logic [1:0]   test_vec;
  logic         update;
  logic         frame_err;

  max7219_rx #(.DEVICES(DEVICES)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi            (spi_if),
    .digit_vector   (digit_vector),
    .seg_vector     (seg_vector),
    .decode_vec     (decode_vec),
    .intensity_vec  (intensity_vec),
    .scan_limit_vec (scan_limit_vec),
    .shutdown_vec   (shutdown_vec),
    .test_vec       (test_vec),
    .update         (update),
    .frame_err      (frame_err)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_loads = 0;
  int   n_upd = 0;
  logic prev_upd = 1'b0;
  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(int nb, logic [95:0] b, int id, logic [127:0] dg, logic [15:0] dc,
                              logic [7:0] in, logic [5:0] sc, logic [1:0] sh, logic [1:0] ts,
                              logic er, logic dt);
    vec_t v;
    v.nbits    = nb;
    v.bits     = b;
    v.e.id     = id;
    v.e.digit  = dg;
    v.e.seg    = dg;
    v.e.decode = dc;
    v.e.inten  = in;
    v.e.scan   = sc;
    v.e.shut   = sh;
    v.e.test   = ts;
    v.e.err    = er;
    v.e.dout   = dt;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (update) begin
      n_upd++;
      check("update_width", 128'(prev_upd), 128'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_update: got update=1 required no update");
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_digit", e.id), digit_vector, e.digit);
        check($sformatf("v%0d_seg", e.id), seg_vector, e.seg);
        check($sformatf("v%0d_decode", e.id), 128'(decode_vec), 128'(e.decode));
        check($sformatf("v%0d_intensity", e.id), 128'(intensity_vec), 128'(e.inten));
        check($sformatf("v%0d_scan", e.id), 128'(scan_limit_vec), 128'(e.scan));
        check($sformatf("v%0d_shutdown", e.id), 128'(shutdown_vec), 128'(e.shut));
        check($sformatf("v%0d_test", e.id), 128'(test_vec), 128'(e.test));
        check($sformatf("v%0d_frame_err", e.id), 128'(frame_err), 128'(e.err));
        check($sformatf("v%0d_dout", e.id), 128'(spi_if.spi_dout), 128'(e.dout));
      end
    end
    prev_upd = update;
  end

  task automatic do_reset();
    @(negedge clk);
    spi_if.spi_din  = 1'b0;
    spi_if.spi_clk  = 1'b0;
    spi_if.spi_load = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    spi_if.spi_din = b;
    repeat (3) @(negedge clk);
    spi_if.spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    spi_if.spi_clk = 1'b0;
  endtask

  task automatic send_bits(input int nb, input logic [95:0] bits);
    for (int i = nb - 1; i >= 0; i--)
      send_bit(bits[i]);
  endtask

  task automatic load_pulse();
    @(negedge clk);
    spi_if.spi_load = 1'b1;
    repeat (4) @(negedge clk);
    spi_if.spi_load = 1'b0;
    repeat (4) @(negedge clk);
    n_loads++;
  endtask

  task automatic wait_sb();
    for (int k = 0; k < 60 && sb.size() != 0; k++)
      @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL update_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_digit"}, digit_vector, 128'd0);
    check({tag, "_seg"}, seg_vector, 128'd0);
    check({tag, "_decode"}, 128'(decode_vec), 128'd0);
    check({tag, "_intensity"}, 128'(intensity_vec), 128'd0);
    check({tag, "_scan"}, 128'(scan_limit_vec), 128'd0);
    check({tag, "_shutdown"}, 128'(shutdown_vec), 128'h3);
    check({tag, "_test"}, 128'(test_vec), 128'd0);
    check({tag, "_update"}, 128'(update), 128'd0);
    check({tag, "_frame_err"}, 128'(frame_err), 128'd0);
    check({tag, "_dout"}, 128'(spi_if.spi_dout), 128'd0);
  endtask

  initial begin
    vec_t vt[12];
    vec_t h;
    spi_if.spi_din  = 1'b0;
    spi_if.spi_clk  = 1'b0;
    spi_if.spi_load = 1'b0;

    vt[0]  = mk(32, 96'h0C01_0000, 0, 128'd0, 16'h0, 8'h00, 6'o00, 2'b01, 2'b00, 1'b0, 1'b0);
    vt[1]  = mk(32, 96'h0312_0157, 1, 128'h0000_0000_0012_0000_0000_0000_0000_0057,
                16'h0, 8'h00, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
    vt[2]  = mk(32, 96'h0F01_0BFF, 2, 128'd0, 16'h0, 8'h00, 6'o07, 2'b11, 2'b10, 1'b0, 1'b0);
    vt[3]  = mk(32, 96'h0A07_0A03, 3, 128'd0, 16'h0, 8'h73, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
    vt[4]  = mk(32, 96'h0C00_0C01, 4, 128'd0, 16'h0, 8'h00, 6'o00, 2'b10, 2'b00, 1'b0, 1'b0);
    vt[5]  = mk(32, 96'hF955_39AA, 5, 128'd0, 16'h55AA, 8'h00, 6'o00, 2'b11, 2'b00, 1'b0, 1'b1);
    vt[6]  = mk(32, 96'h0D12_0E34, 6, 128'd0, 16'h0, 8'h00, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
    vt[7]  = mk(32, 96'h0F00_0F01, 7, 128'd0, 16'h0, 8'h00, 6'o00, 2'b11, 2'b01, 1'b0, 1'b0);
    vt[8]  = mk(33, 96'h1_0A05_0A06, 8, 128'd0, 16'h0, 8'h56, 6'o00, 2'b11, 2'b00, 1'b1, 1'b0);
    vt[9]  = mk(16, 96'h0A09, 9, 128'd0, 16'h0, 8'h09, 6'o00, 2'b11, 2'b00, 1'b1, 1'b0);
    vt[10] = mk(32, 96'h0B03_0808, 10, 128'h0000_0000_0000_0000_0800_0000_0000_0000,
                16'h0, 8'h00, 6'o30, 2'b11, 2'b00, 1'b0, 1'b0);
    vt[11] = mk(96, {64'd0, 32'h0A01_0A02}, 11, 128'd0, 16'h0, 8'h12, 6'o00, 2'b11, 2'b00, 1'b1, 1'b0);
`ifdef MAX7219_RX_DECODE_EN
    vt[5].e.seg = 128'h007E_007E_007E_007E_7E00_7E00_7E00_7E00;
`endif

    do_reset();
    check_idle("reset");

    for (int i = 0; i < 12; i++) begin
      do_reset();
      send_bits(vt[i].nbits, vt[i].bits);
      sb.push_back(vt[i].e);
      load_pulse();
      wait_sb();
    end

    // Short frame keeps its partial contents; the following full frame clears the error.
    do_reset();
    send_bits(31, 96'h0A05_0A03);
    h = mk(0, 96'd0, 20, 128'd0, 16'h0, 8'h53, 6'o00, 2'b11, 2'b00, 1'b1, 1'b0);
    sb.push_back(h.e);
    load_pulse();
    wait_sb();
    send_bits(32, 96'h0A07_0A02);
    h = mk(0, 96'd0, 21, 128'd0, 16'h0, 8'h72, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
    sb.push_back(h.e);
    load_pulse();
    wait_sb();

    // Reset in the middle of a frame must discard the partial bits and count.
    do_reset();
    send_bits(20, 96'hF_FFFF);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(32, 96'h0A07_0A03);
    h = mk(0, 96'd0, 22, 128'd0, 16'h0, 8'h73, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
    sb.push_back(h.e);
    load_pulse();
    wait_sb();

    // Last clock and load rise together: the final bit belongs to the latched frame.
    do_reset();
    send_bits(31, 96'(32'h0C01_0A0B >> 1));
    @(negedge clk);
    spi_if.spi_din = 1'b1;
    repeat (3) @(negedge clk);
    h = mk(0, 96'd0, 23, 128'd0, 16'h0, 8'h0B, 6'o00, 2'b01, 2'b00, 1'b0, 1'b0);
    sb.push_back(h.e);
    spi_if.spi_clk  = 1'b1;
    spi_if.spi_load = 1'b1;
    repeat (4) @(negedge clk);
    spi_if.spi_clk  = 1'b0;
    spi_if.spi_load = 1'b0;
    repeat (4) @(negedge clk);
    n_loads++;
    wait_sb();

    // Decode mode on device 0 digit 0.
    do_reset();
    send_bits(32, 96'h0000_0901);
    h = mk(0, 96'd0, 24, 128'd0, 16'h0001, 8'h00, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
`ifdef MAX7219_RX_DECODE_EN
    h.e.seg = 128'h7E;
`endif
    sb.push_back(h.e);
    load_pulse();
    wait_sb();
    send_bits(32, 96'h0000_0185);
    h = mk(0, 96'd0, 25, 128'h85, 16'h0001, 8'h00, 6'o00, 2'b11, 2'b00, 1'b0, 1'b0);
`ifdef MAX7219_RX_DECODE_EN
    h.e.seg = 128'hDB;
`endif
    sb.push_back(h.e);
    load_pulse();
    wait_sb();

    check("update_count", 128'(n_upd), 128'(n_loads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
# max7219_rx

Serial receiver model of a daisy-chained MAX7219 LED driver: the far end of the display SPI link driven by the existing MAX7219 transmitter. It oversamples the three-wire link (DIN/CLK/LOAD) on the system clock and shifts a chain of `DEVICES` 16-bit frames. On each LOAD rising edge it decodes every device's frame into a register file of digits and control registers, and exposes them as flat vectors. It is used for self-checking benches and for mirroring the MAX7219 digit data onto the on-board LED_DIG/LED_SEG multiplexer.

## Interface
Parameters:
- `DEVICES`, default 2: number of chained MAX7219s modelled (1–8).

Ports:
- `clk`  in  1: system clock. Must run at least 4× the SPI clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `spi_din`  in  1: serial data (transmitter `data_out`).
- `spi_clk`  in  1: serial clock (transmitter `clk_out`).
- `spi_load`  in  1: load/chip select (transmitter `load_out`).
- `spi_dout`  out  1: chain output, MSB of the shift register.
- `digit_vector`  out  64*DEVICES: raw digit registers. Device d, digit n is at `[64*d+8*n +: 8]`.
- `seg_vector`  out  64*DEVICES: segment patterns, same layout as `digit_vector`.
- `decode_vec`  out  8*DEVICES: decode-mode register per device.
- `intensity_vec`  out  4*DEVICES: intensity register per device.
- `scan_limit_vec`  out  3*DEVICES: scan-limit register per device.
- `shutdown_vec`  out  DEVICES: 1 = device in shutdown.
- `test_vec`  out  DEVICES: display-test register per device.
- `update`  out  1: one-cycle pulse when the registers are latched.
- `frame_err`  out  1: the last latch saw a bit count ≠ 16*DEVICES.

## Operation
- **Input sampling:** `spi_din`, `spi_clk` and `spi_load` each pass through a 2-flop synchronizer followed by one edge-detect register.
- **Shifting:** on each sampled `spi_clk` rise, shift `{sr[16*DEVICES-2:0], din}`. Shifting happens regardless of the load level.
- **Bit counter:** increments on each shifted bit and saturates at 16*DEVICES+1. It clears on each load rise.
- **Latch:** on a sampled `spi_load` rise, slice the frame for device d as `sr[16*d +: 16]`.
  - Device 0 is nearest the transmitter, so it holds the last word sent.
- **Address decode,** address = `frame[11:8]`, data = `frame[7:0]`:
  - 0x0: no-op, device unchanged.
  - 0x1–0x8: digit 0–7.
  - 0x9: decode mode.
  - 0xA: intensity ← `data[3:0]`.
  - 0xB: scan limit ← `data[2:0]`.
  - 0xC: shutdown ← `~data[0]`.
  - 0xD, 0xE: ignored.
  - 0xF: display test ← `data[0]`.
  - Bits [15:12] are ignored.
- **Frame error:** `frame_err` is written at every latch: 1 if the bit count ≠ 16*DEVICES, else 0. Registers are still updated from whatever is in the shift register, matching the hardware.
- **Segment bit order:** D7 = DP, D6 = A … D0 = G.
- **Reset values:** all outputs 0, except `shutdown_vec` = all ones. The shift register, counter and synchronizers also clear to 0.

## Timing
- A pin edge is visible to the edge detector 3 `clk` cycles later.
- A shift happens on the cycle the edge is detected.
- The register file and `frame_err` update 1 cycle after a load rise is detected.
- `update` pulses high in that same cycle, so the new values are valid while `update` = 1.
- **Simultaneous clock and load rise** in one sampled cycle: shift first, then latch including the new bit.
- **Reset mid-frame:** everything returns to reset values immediately. A partial frame is discarded.
- **Minimum SPI timing:** high and low phases of `spi_clk` and `spi_load` must each last ≥ 2 `clk` periods.
- `spi_dout` changes on the shift cycle.

## Configuration
- `MAX7219_RX_DECODE_EN` defined:
  - For each digit n of device d with `decode_vec[8*d+n]` = 1, the segment output is Code-B decoded from the low nibble.
  - Nibble 0–9 gives the digit glyph; A = '-', B = 'E', C = 'H', D = 'L', E = 'P', F = blank.
  - DP (bit 7) is passed through from `data[7]`.
  - Digits whose decode bit is 0 pass through raw.
- Undefined: `seg_vector` equals `digit_vector` and decode mode has no effect on it. The decode register is still stored.

## Structure
- **Package `max7219_pkg`:**
  - address enum (NOOP, DIGIT0–7, DECODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, TEST).
  - Code-B glyph constant table.
  - reset constants.
- **Sub-module `max7219_code_b`:** combinational, 8-bit digit in → 8-bit segments out. Instantiated per digit inside a generate, and only under the macro.

## Test plan
- **Chain word order:** DEVICES = 2; send 0x0C01 then 0x0000, then raise load → `shutdown_vec` = 2'b01, `update` pulses once, `frame_err` = 0.
- **Digit mapping:** send 0x0312 then 0x0157, then load → `digit_vector[64+16 +: 8]` = 0x12, `digit_vector[0 +: 8]` = 0x57, all other digits 0.
- **Short frame:** 31 clocks then load → `frame_err` = 1 and registers updated from the partial shift. The next 32-clock frame → `frame_err` = 0.
- **Decode:** device 0 writes decode 0x01 and digit0 0x85 → with the macro, `seg_vector[7:0]` = 0xDB; without it, 0x85.
- **Reset mid-frame:** assert `reset_n` low after 20 bits, release, send a full frame 0x0A07/0x0A03 → `intensity_vec` = 8'h73, no residue from the partial frame.
- **Control registers:** address 0xF data 0x01 then 0xB data 0xFF → `test_vec` bit set, scan limit = 7. Address 0xD leaves all registers unchanged.
